// File: rtl/dmem_arb_pkg.sv
// Shared types and default widths for the data-memory port arbiter.
// The arbiter's force path is enabled by defining DMEM_ARB_STARVE_EN.
package dmem_arb_pkg;

    localparam int unsigned DEF_ADDR_W       = 32;
    localparam int unsigned DEF_DATA_W       = 32;
    localparam int unsigned DEF_STARVE_LIMIT = 8;

    // Who owned data_mem in the cycle that just ended.
    typedef enum logic [1:0] {
        ARB_IDLE  = 2'd0,
        ARB_CPU   = 2'd1,
        ARB_DMA   = 2'd2,
        ARB_FORCE = 2'd3
    } arb_state_t;

endpackage

// File: rtl/dmem_arb_starve_cnt.sv
// Saturating count of consecutive cycles a DMA request has been refused.
// Instantiated only when DMEM_ARB_STARVE_EN is defined.
module dmem_arb_starve_cnt #(
    parameter int unsigned LIMIT = 8
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic incr,
    output logic at_limit
);

    localparam int unsigned CNT_W = $clog2(LIMIT + 1);
    localparam logic [CNT_W-1:0] LIMIT_C = CNT_W'(LIMIT);

    logic [CNT_W-1:0] count;

    assign at_limit = (count == LIMIT_C);

    // NOTE: registers use non-blocking assignment so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (reset || clear) begin
            count <= '0;
        end else if (incr && !at_limit) begin
            count <= count + 1'b1;
        end
    end

endmodule

// File: rtl/dmem_port_arbiter.sv
// Shares single-port data_mem between the MEM stage (fixed priority) and a DMA port.
// Define DMEM_ARB_STARVE_EN to add the bounded anti-starvation forced DMA grant.
module dmem_port_arbiter
    import dmem_arb_pkg::*;
#(
    parameter int unsigned ADDR_W       = DEF_ADDR_W,
    parameter int unsigned DATA_W       = DEF_DATA_W,
    parameter int unsigned STARVE_LIMIT = DEF_STARVE_LIMIT
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              cpu_req,
    input  logic              cpu_wr_en,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wr_data,
    output logic [DATA_W-1:0] cpu_rd_data,
    output logic              cpu_stall,
    input  logic              dma_req,
    input  logic              dma_wr_en,
    input  logic [ADDR_W-1:0] dma_addr,
    input  logic [DATA_W-1:0] dma_wr_data,
    output logic              dma_gnt,
    output logic [DATA_W-1:0] dma_rd_data,
    output logic              dma_rd_valid,
    output logic              mem_wr_en,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wr_data,
    input  logic [DATA_W-1:0] mem_rd_data
);

    if (STARVE_LIMIT < 1 || STARVE_LIMIT > 255) begin : g_bad_limit
        $error("dmem_port_arbiter: STARVE_LIMIT must lie in 1..255");
    end

    arb_state_t state;
    arb_state_t next_state;
    logic       force_gnt;
    logic       cpu_gnt;

`ifdef DMEM_ARB_STARVE_EN
    logic at_limit;

    // A refused request counts up; any grant or a withdrawn request starts over.
    dmem_arb_starve_cnt #(
        .LIMIT (STARVE_LIMIT)
    ) u_starve_cnt (
        .clk      (clk),
        .reset    (reset),
        .clear    (!dma_req || dma_gnt),
        .incr     (dma_req && !dma_gnt),
        .at_limit (at_limit)
    );

    assign force_gnt = at_limit && dma_req;
    assign cpu_stall = cpu_req && dma_gnt;
`else
    assign force_gnt = 1'b0;
    assign cpu_stall = 1'b0;
`endif

    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        next_state = ARB_IDLE;
        if (!reset) begin
            if (force_gnt) begin
                next_state = ARB_FORCE;
            end else if (cpu_req) begin
                next_state = ARB_CPU;
            end else if (dma_req) begin
                next_state = ARB_DMA;
            end
        end
    end

    assign cpu_gnt = (next_state == ARB_CPU);
    assign dma_gnt = (next_state == ARB_DMA) || (next_state == ARB_FORCE);

    // Only the granted port reaches data_mem; with no owner the bus is parked at zero.
    always_comb begin
        mem_wr_en   = 1'b0;
        mem_addr    = '0;
        mem_wr_data = '0;
        if (dma_gnt) begin
            mem_wr_en   = dma_wr_en;
            mem_addr    = dma_addr;
            mem_wr_data = dma_wr_data;
        end else if (cpu_gnt) begin
            mem_wr_en   = cpu_wr_en;
            mem_addr    = cpu_addr;
            mem_wr_data = cpu_wr_data;
        end
    end

    assign cpu_rd_data = mem_rd_data;

    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= ARB_IDLE;
            dma_rd_valid <= 1'b0;
            dma_rd_data  <= '0;
        end else begin
            state        <= next_state;
            dma_rd_valid <= dma_gnt && !dma_wr_en;
            if (dma_gnt && !dma_wr_en) begin
                dma_rd_data <= mem_rd_data;
            end
        end
    end

endmodule

// File: tb/tb_dmem_port_arbiter.sv
// Directed self-checking bench for dmem_port_arbiter with a small data_mem model.
// Expectations follow DMEM_ARB_STARVE_EN so the bench suits either build.
module tb_dmem_port_arbiter;
    import dmem_arb_pkg::*;

    logic        clk = 1'b0;
    logic        reset;
    logic        cpu_req, cpu_wr_en;
    logic [31:0] cpu_addr, cpu_wr_data;
    logic        dma_req, dma_wr_en;
    logic [31:0] dma_addr, dma_wr_data;

    logic [31:0] cpu_rd_data, dma_rd_data, mem_addr, mem_wr_data, mem_rd_data;
    logic        cpu_stall, dma_gnt, dma_rd_valid, mem_wr_en;

    logic [31:0] l1_cpu_rd_data, l1_dma_rd_data, l1_mem_addr, l1_mem_wr_data;
    logic        l1_cpu_stall, l1_dma_gnt, l1_dma_rd_valid, l1_mem_wr_en;

    logic [31:0] mem [0:255];

    int n_cmp = 0;
    int n_bad = 0;
    logic [63:0] exp_q [$];

    always #5 clk = ~clk;

    dmem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .STARVE_LIMIT(8)) dut (
        .clk(clk), .reset(reset),
        .cpu_req(cpu_req), .cpu_wr_en(cpu_wr_en), .cpu_addr(cpu_addr), .cpu_wr_data(cpu_wr_data),
        .cpu_rd_data(cpu_rd_data), .cpu_stall(cpu_stall),
        .dma_req(dma_req), .dma_wr_en(dma_wr_en), .dma_addr(dma_addr), .dma_wr_data(dma_wr_data),
        .dma_gnt(dma_gnt), .dma_rd_data(dma_rd_data), .dma_rd_valid(dma_rd_valid),
        .mem_wr_en(mem_wr_en), .mem_addr(mem_addr), .mem_wr_data(mem_wr_data),
        .mem_rd_data(mem_rd_data)
    );

    // Second instance shares the stimulus to exercise the tightest force interval.
    dmem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .STARVE_LIMIT(1)) dut_l1 (
        .clk(clk), .reset(reset),
        .cpu_req(cpu_req), .cpu_wr_en(cpu_wr_en), .cpu_addr(cpu_addr), .cpu_wr_data(cpu_wr_data),
        .cpu_rd_data(l1_cpu_rd_data), .cpu_stall(l1_cpu_stall),
        .dma_req(dma_req), .dma_wr_en(dma_wr_en), .dma_addr(dma_addr), .dma_wr_data(dma_wr_data),
        .dma_gnt(l1_dma_gnt), .dma_rd_data(l1_dma_rd_data), .dma_rd_valid(l1_dma_rd_valid),
        .mem_wr_en(l1_mem_wr_en), .mem_addr(l1_mem_addr), .mem_wr_data(l1_mem_wr_data),
        .mem_rd_data(32'h0)
    );

    assign mem_rd_data = mem[mem_addr[9:2]];

    always @(posedge clk) begin
        if (mem_wr_en) mem[mem_addr[9:2]] <= mem_wr_data;
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic check_pop(input string tag, input logic [63:0] obs);
        logic [63:0] e;
        if (exp_q.size() == 0) begin
            n_cmp++;
            n_bad++;
            $error("FAIL %s: scoreboard empty, observed 0x%0h", tag, obs);
        end else begin
            e = exp_q.pop_front();
            check(tag, obs, e);
        end
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic sample();
        @(negedge clk);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_gnt"},     dma_gnt, 1'b0);
        check({tag, "_stall"},   cpu_stall, 1'b0);
        check({tag, "_wr_en"},   mem_wr_en, 1'b0);
        check({tag, "_addr"},    mem_addr, 32'h0);
        check({tag, "_wr_data"}, mem_wr_data, 32'h0);
        check({tag, "_valid"},   dma_rd_valid, 1'b0);
        check({tag, "_rd_data"}, dma_rd_data, 32'h0);
        check({tag, "_state"},   dut.state, ARB_IDLE);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time budget");
        $fatal(1, "watchdog expired");
    end

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = 32'h0;
        reset = 1'b1;
        cpu_req = 1'b1; cpu_wr_en = 1'b1; cpu_addr = 32'h44; cpu_wr_data = 32'h5A5A5A5A;
        dma_req = 1'b1; dma_wr_en = 1'b1; dma_addr = 32'h48; dma_wr_data = 32'hA5A5A5A5;

        // Reset held with both ports requesting: nothing reaches data_mem.
        next_cycle();
        next_cycle();
        sample();
        check_reset_outputs("rst_init");

        // CPU store then load, no DMA.
        next_cycle();
        reset = 1'b0;
        dma_req = 1'b0;
        cpu_req = 1'b1; cpu_wr_en = 1'b1; cpu_addr = 32'h10; cpu_wr_data = 32'hDEADBEEF;
        sample();
        check("cpu_st_wr_en", mem_wr_en, 1'b1);
        check("cpu_st_addr", mem_addr, 32'h10);
        check("cpu_st_data", mem_wr_data, 32'hDEADBEEF);
        check("cpu_st_gnt", dma_gnt, 1'b0);
        next_cycle();
        cpu_wr_en = 1'b0;
        exp_q.push_back(64'hDEADBEEF);
        sample();
        check_pop("cpu_ld_data", cpu_rd_data);
        check("cpu_ld_stall", cpu_stall, 1'b0);
        check("cpu_ld_wr_en", mem_wr_en, 1'b0);

        // Idle CPU: DMA write then DMA read of the same word.
        next_cycle();
        cpu_req = 1'b0;
        dma_req = 1'b1; dma_wr_en = 1'b1; dma_addr = 32'h20; dma_wr_data = 32'h12345678;
        sample();
        check("dma_wr_gnt", dma_gnt, 1'b1);
        check("dma_wr_addr", mem_addr, 32'h20);
        check("dma_wr_en", mem_wr_en, 1'b1);
        next_cycle();
        dma_wr_en = 1'b0;
        exp_q.push_back(64'h12345678);
        sample();
        check("dma_rd_gnt", dma_gnt, 1'b1);
        check("dma_wr_no_valid", dma_rd_valid, 1'b0);
        check("dma_rd_no_wr", mem_wr_en, 1'b0);
        next_cycle();
        dma_req = 1'b0;
        sample();
        check("dma_rd_valid", dma_rd_valid, 1'b1);
        check_pop("dma_rd_data", dma_rd_data);
        check("dma_idle_gnt", dma_gnt, 1'b0);
        next_cycle();
        sample();
        check("dma_valid_drop", dma_rd_valid, 1'b0);
        check("dma_data_hold", dma_rd_data, 32'h12345678);

        // Contention: CPU store held, DMA write held.
        next_cycle();
        cpu_req = 1'b1; cpu_wr_en = 1'b1; cpu_addr = 32'h30; cpu_wr_data = 32'hAAAA5555;
        dma_req = 1'b1; dma_wr_en = 1'b1; dma_addr = 32'h34; dma_wr_data = 32'h0BADF00D;
`ifdef DMEM_ARB_STARVE_EN
        for (int c = 1; c <= 9; c++) begin
            sample();
            check($sformatf("starve_gnt_c%0d", c), dma_gnt, (c == 9));
            check($sformatf("starve_stall_c%0d", c), cpu_stall, (c == 9));
            check($sformatf("lim1_gnt_c%0d", c), l1_dma_gnt, (c % 2 == 0));
            if (c == 9) begin
                check("force_addr", mem_addr, 32'h34);
                check("force_wr_data", mem_wr_data, 32'h0BADF00D);
                check("force_wr_en", mem_wr_en, 1'b1);
            end
            next_cycle();
        end
        dma_req = 1'b0;
        sample();
        check("after_force_gnt", dma_gnt, 1'b0);
        check("after_force_stall", cpu_stall, 1'b0);
        check("after_force_addr", mem_addr, 32'h30);
        check("after_force_state", dut.state, ARB_FORCE);
        next_cycle();
        cpu_wr_en = 1'b0; cpu_addr = 32'h34;
        exp_q.push_back(64'h0BADF00D);
        sample();
        check("cpu_after_force_state", dut.state, ARB_CPU);
        check_pop("force_wr_commit", cpu_rd_data);
`else
        for (int c = 1; c <= 50; c++) begin
            sample();
            check($sformatf("nostarve_gnt_c%0d", c), dma_gnt, 1'b0);
            check($sformatf("nostarve_stall_c%0d", c), cpu_stall, 1'b0);
            check($sformatf("nostarve_l1_gnt_c%0d", c), l1_dma_gnt, 1'b0);
            next_cycle();
        end
        cpu_req = 1'b0;
        sample();
        check("idle_cpu_dma_gnt", dma_gnt, 1'b1);
        check("idle_cpu_dma_addr", mem_addr, 32'h34);
        next_cycle();
        dma_req = 1'b0;
        cpu_req = 1'b1; cpu_wr_en = 1'b0; cpu_addr = 32'h34;
        exp_q.push_back(64'h0BADF00D);
        sample();
        check_pop("dma_wr_commit", cpu_rd_data);
`endif

        // Reset lands on the edge that would deliver a granted DMA read.
        next_cycle();
        cpu_req = 1'b0;
        dma_req = 1'b1; dma_wr_en = 1'b0; dma_addr = 32'h20;
        sample();
        check("rst_mid_gnt", dma_gnt, 1'b1);
        #1;
        reset = 1'b1;
        dma_req = 1'b0;
        cpu_req = 1'b1; cpu_wr_en = 1'b1; cpu_addr = 32'h40; cpu_wr_data = 32'h00000055;
        next_cycle();
        sample();
        check_reset_outputs("rst_mid");

        // Request withdrawn for one cycle restarts the starvation count.
        next_cycle();
        reset = 1'b0;
        cpu_req = 1'b1; cpu_wr_en = 1'b0; cpu_addr = 32'h10;
        dma_req = 1'b1; dma_wr_en = 1'b0; dma_addr = 32'h20;
        for (int c = 1; c <= 5; c++) begin
            sample();
            check($sformatf("pulse_gnt_c%0d", c), dma_gnt, 1'b0);
            next_cycle();
        end
        dma_req = 1'b0;
        sample();
        check("drop_gnt", dma_gnt, 1'b0);
        next_cycle();
        dma_req = 1'b1;
`ifdef DMEM_ARB_STARVE_EN
        for (int c = 1; c <= 9; c++) begin
            sample();
            check($sformatf("rearm_gnt_c%0d", c), dma_gnt, (c == 9));
            next_cycle();
        end
        dma_req = 1'b0;
        exp_q.push_back(64'h12345678);
        sample();
        check("rearm_rd_valid", dma_rd_valid, 1'b1);
        check_pop("rearm_rd_data", dma_rd_data);
`else
        for (int c = 1; c <= 15; c++) begin
            sample();
            check($sformatf("rearm_gnt_c%0d", c), dma_gnt, 1'b0);
            next_cycle();
        end
        dma_req = 1'b0;
        sample();
        check("rearm_no_valid", dma_rd_valid, 1'b0);
`endif

        next_cycle();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/dmem_port_arbiter.md
Name: dmem_port_arbiter

Overview:
- Shares the single-port data memory between the pipeline MEM stage (CPU port) and a DMA/loader port.
- The CPU has fixed priority. DMA is served in idle CPU cycles or through a bounded anti-starvation forced grant, which stalls the pipeline for one cycle.
- Sits between the MEM stage and data_mem. It drives data_mem wr_en/addr/wr_data and fans rd_data back to the CPU and DMA ports.

Parameters:
- ADDR_W, 32, address width for both ports and data_mem
- DATA_W, 32, data width
- STARVE_LIMIT, 8, consecutive denied DMA-request cycles before a forced DMA grant (range 1..255)

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  synchronous, active-high reset
- cpu_req  in  1  MEM stage accesses memory this cycle (load or store)
- cpu_wr_en  in  1  CPU store
- cpu_addr  in  ADDR_W  CPU address (ALU result)
- cpu_wr_data  in  DATA_W  CPU store data
- cpu_rd_data  out  DATA_W  CPU load data, combinational from mem_rd_data
- cpu_stall  out  1  MEM stage not served; pipeline must freeze and hold all MEM inputs
- dma_req  in  1  DMA transfer pending; held until granted
- dma_wr_en  in  1  DMA write
- dma_addr  in  ADDR_W  DMA address
- dma_wr_data  in  DATA_W  DMA write data
- dma_gnt  out  1  DMA transfer occurs this cycle
- dma_rd_data  out  DATA_W  registered DMA read data
- dma_rd_valid  out  1  dma_rd_data valid, one cycle after a granted DMA read
- mem_wr_en  out  1  to data_mem wr_en
- mem_addr  out  ADDR_W  to data_mem addr
- mem_wr_data  out  DATA_W  to data_mem wr_data
- mem_rd_data  in  DATA_W  from data_mem (asynchronous read)

Behaviour:
- Grant decision is combinational each cycle, using the current requests plus the registered starve counter. Priority order:
  1. reset=1: no grant.
  2. force: starve_cnt==STARVE_LIMIT and dma_req → DMA granted.
  3. cpu_req → CPU granted.
  4. dma_req → DMA granted.
  5. Otherwise: no grant.
- cpu_stall = cpu_req && DMA granted. It is asserted only in a force cycle.
- Memory mux:
  - DMA granted: mem_* = dma_*.
  - CPU granted: mem_* = cpu_*.
  - No grant: mem_wr_en=0, mem_addr=0, mem_wr_data=0.
- mem_wr_en is never 1 for a port that is not granted. Writes commit at the rising edge that ends the grant cycle.
- cpu_rd_data = mem_rd_data, zero latency; it is meaningful only in CPU grant cycles.
- DMA handshake:
  - A transfer occurs on a cycle with dma_req && dma_gnt.
  - DMA must hold req/addr/data/wr_en stable until granted.
  - A new request may be presented the cycle after a grant.
- DMA read:
  - Next edge after a granted read: dma_rd_data ← mem_rd_data, dma_rd_valid ← 1.
  - Otherwise dma_rd_valid ← 0 and dma_rd_data holds its value.
  - Granted DMA writes do not raise dma_rd_valid.
- starve_cnt (width clog2(STARVE_LIMIT+1)):
  - Cleared on reset, on any dma_gnt, or when dma_req=0.
  - Otherwise increments when dma_req && !dma_gnt, saturating at STARVE_LIMIT.
- Owner state register, updated every edge:
  - ARB_IDLE: no grant.
  - ARB_CPU: CPU granted.
  - ARB_DMA: normal DMA grant.
  - ARB_FORCE: forced DMA grant.
  - Used for status/assertions.
  - ARB_FORCE is always followed by ARB_CPU if cpu_req is held, because the counter is cleared on the grant.
- Reset values: state=ARB_IDLE, starve_cnt=0, dma_rd_valid=0, dma_rd_data=0. During reset: dma_gnt=0, cpu_stall=0, mem_wr_en=0, mem_addr=0, mem_wr_data=0.
- Boundary conditions:
  - Reset asserted mid-DMA read: pending dma_rd_valid is suppressed at that edge.
  - dma_req dropped while waiting: counter clears and no grant is issued.
  - STARVE_LIMIT=1: a forced grant is issued at most every other cycle.

Optional Feature:
- Macro: DMEM_ARB_STARVE_EN.
- Defined: anti-starvation counter, force path, and ARB_FORCE state are compiled in, as described above.
- Undefined:
  - Counter and ARB_FORCE are compiled out.
  - cpu_stall is tied to 0.
  - DMA is served only in cycles with cpu_req=0 and may starve indefinitely.

Decomposition:
- Package dmem_arb_pkg: arb_state_t (ARB_IDLE, ARB_CPU, ARB_DMA, ARB_FORCE), ADDR_W/DATA_W defaults.
- Sub-module dmem_arb_starve_cnt: saturating counter with clear, increment, and at_limit output; instantiated only under DMEM_ARB_STARVE_EN.

Test Plan:
- CPU store then load, no DMA: cpu_req=1, wr addr 0x10 data 0xDEADBEEF; next cycle read addr 0x10 → cpu_rd_data=0xDEADBEEF same cycle; dma_gnt=0; cpu_stall=0.
- Idle CPU, DMA write 0x20=0x12345678 then DMA read 0x20 → dma_gnt in each cycle; dma_rd_valid=1 with 0x12345678 one cycle after the read grant.
- cpu_req held high, dma_req high, flag on → dma_gnt=0 for 8 cycles; cycle 9 dma_gnt=1, cpu_stall=1, CPU write suppressed (mem_addr=dma_addr); cycle 10 CPU granted, cpu_stall=0.
- Same stimulus, flag off → dma_gnt never asserted over 50 cycles; cpu_stall stays 0.
- DMA read granted, reset asserted on the following edge → dma_rd_valid=0, dma_rd_data=0, state=ARB_IDLE, all mem_* outputs 0 during reset.
- dma_req pulsed for 5 denied cycles, dropped for 1, reasserted with cpu_req held → forced grant arrives only after 8 further denied cycles (counter cleared by the drop).
